// File: rtl/spi_wb_bridge.sv
// spi_wb_bridge: oversampled SPI mode-0 slave that drives a Wishbone master, one command per SS-low frame.
// Define SPI_BURST_EN for auto-increment write bursts and prefetched read bursts; undefined = one data word per frame.
module spi_wb_bridge #(
    parameter int unsigned DW          = 8,
    parameter int unsigned AW          = 7,
    parameter int unsigned TO_CYC      = 255,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          spi_sck,
    input  logic          spi_ss,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    input  logic          wb_ack_i,
    output logic          timeout_o
);

`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    localparam int unsigned CW  = $clog2(DW);
    localparam int unsigned TOW = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, CMD, WR_DATA, WR_EXE, RD_EXE, RD_LOAD, RD_DATA, DONE
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sck_sq, ss_sq, mosi_sq;
    logic                   sck_prev_q, ss_prev_q;
    logic [CW-1:0]          cnt_q;
    logic [DW-2:0]          rx_q;
    logic [DW-1:0]          rx_d, tx_q, rd_q, dat_q;
    logic [AW-1:0]          adr_q;
    logic [TOW-1:0]         to_q;
    logic                   cyc_q, we_q, timeout_q, ld_pend_q, ld_arm_q;
    logic                   sck_s, ss_s, mosi_s;
    logic                   sck_rise, sck_fall, ss_fall, word_done, boundary, ack, to_hit;

    assign sck_s     = sck_sq[SYNC_STAGES-1];
    assign ss_s      = ss_sq[SYNC_STAGES-1];
    assign mosi_s    = mosi_sq[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;
    assign word_done = sck_rise & ~ss_s & (cnt_q == CW'(DW - 1));
    // Counter is back at 0 on the falling edge that follows a completed word.
    assign boundary  = sck_fall & ~ss_s & (cnt_q == '0);
    assign rx_d      = {rx_q, mosi_s};
    assign ack       = wb_ack_i & cyc_q;
    assign to_hit    = cyc_q & ~wb_ack_i & (to_q == TOW'(TO_CYC - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sck_sq     <= '0;
            ss_sq      <= '1;
            mosi_sq    <= '0;
            sck_prev_q <= 1'b0;
            ss_prev_q  <= 1'b1;
            cnt_q      <= '0;
            rx_q       <= '0;
        end else begin
            sck_sq     <= {sck_sq[SYNC_STAGES-2:0], spi_sck};
            ss_sq      <= {ss_sq[SYNC_STAGES-2:0], spi_ss};
            mosi_sq    <= {mosi_sq[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q <= sck_s;
            ss_prev_q  <= ss_s;
            if (ss_s) begin
                cnt_q <= '0;
            end else if (sck_rise) begin
                rx_q  <= rx_d[DW-2:0];
                cnt_q <= (cnt_q == CW'(DW - 1)) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rd_q      <= '0;
            dat_q     <= '0;
            adr_q     <= '0;
            to_q      <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            timeout_q <= 1'b0;
            ld_pend_q <= 1'b0;
            ld_arm_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            to_q      <= cyc_q ? to_q + 1'b1 : '0;
            // Read data waits for the end of the word in which it arrived, so DUMMY always shifts 0.
            if (word_done && ld_pend_q) begin
                ld_arm_q  <= 1'b1;
                ld_pend_q <= 1'b0;
            end
            if (boundary) begin
                tx_q     <= ld_arm_q ? rd_q : '0;
                ld_arm_q <= 1'b0;
            end else if (sck_fall) begin
                tx_q <= {tx_q[DW-2:0], 1'b0};
            end

            case (state_q)
                IDLE: begin
                    tx_q      <= '0;
                    ld_pend_q <= 1'b0;
                    ld_arm_q  <= 1'b0;
                    if (ss_fall) state_q <= CMD;
                end
                CMD: begin
                    if (ss_s) begin
                        state_q <= IDLE;
                    end else if (word_done) begin
                        adr_q <= rx_d[AW-1:0];
                        if (rx_d[DW-1]) begin
                            state_q <= WR_DATA;
                        end else begin
                            cyc_q   <= 1'b1;
                            we_q    <= 1'b0;
                            state_q <= RD_EXE;
                        end
                    end
                end
                WR_DATA: begin
                    if (ss_s) begin
                        state_q <= IDLE;
                    end else if (word_done) begin
                        dat_q   <= rx_d;
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b1;
                        state_q <= WR_EXE;
                    end
                end
                WR_EXE, RD_EXE: begin
                    if (ack || to_hit) begin
                        cyc_q     <= 1'b0;
                        we_q      <= 1'b0;
                        timeout_q <= to_hit;
                        if (!we_q && !ss_s) begin
                            rd_q      <= to_hit ? '1 : wb_dat_i;
                            ld_pend_q <= 1'b1;
                        end
                        if (ss_s) begin
                            state_q <= IDLE;
                        end else if (to_hit) begin
                            state_q <= DONE;
                        end else if (!we_q) begin
                            state_q <= RD_LOAD;
                        end else if (BURST) begin
                            adr_q   <= adr_q + 1'b1;
                            state_q <= WR_DATA;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                RD_LOAD: begin
                    if (ss_s) state_q <= IDLE;
                    else if (boundary && ld_arm_q) state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (ss_s) begin
                        state_q <= IDLE;
                    end else if (word_done) begin
                        if (BURST) begin
                            adr_q   <= adr_q + 1'b1;
                            cyc_q   <= 1'b1;
                            state_q <= RD_EXE;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (ss_s) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_miso  = ~spi_ss & tx_q[DW-1];
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign timeout_o = timeout_q;

endmodule
